// File: rtl/dav_pkg.sv
// Shared types for the peak-scan colour path: FSM states, bank select and index sizing.
package dav_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      PUBLISH
   } scan_state_e;

   typedef logic bank_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Running argmax over a stream of magnitudes; strict greater-than so ties keep the earliest index.
module argmax_tracker
   import dav_pkg::*;
#(
   parameter int unsigned MAG_W = 16,
   parameter int unsigned IDX_W = idx_width(32)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             valid,
   input  logic [MAG_W-1:0] data,
   input  logic [IDX_W-1:0] idx,
   output logic [MAG_W-1:0] best_mag,
   output logic [IDX_W-1:0] best_idx
);

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         best_mag <= '0;
         best_idx <= '0;
      end else if (valid && (data > best_mag)) begin
         best_mag <= data;
         best_idx <= idx;
      end
   end

endmodule

// File: rtl/peak_scan_ctrl.sv
// Frame scan controller: bank ping-pong, argmax scan and peak publish to the colour stage.
// Optional peak hold selected by defining PEAK_HOLD_EN.
module peak_scan_ctrl
   import dav_pkg::*;
#(
   parameter int unsigned SAMPLES     = 32,
   parameter int unsigned MAG_W       = 16,
   parameter int unsigned HOLD_FRAMES = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       frame_ready,
   input  logic [MAG_W-1:0]           thresh,
   output logic                       rd_en,
   output logic [$clog2(SAMPLES)-1:0] rd_addr,
   input  logic [MAG_W-1:0]           rd_data,
   output logic [$clog2(SAMPLES)-1:0] index_holder,
   output logic                       whichRAM,
   output logic                       done,
   output logic                       busy,
   output logic                       frame_drop
);

   localparam int unsigned IW = idx_width(SAMPLES);

   scan_state_e       state, state_next;
   bank_t             bank;
   logic              pending;
   logic [IW-1:0]     counter;
   logic              rd_valid;
   logic [IW-1:0]     rd_idx;
   logic              accept;
   logic [MAG_W-1:0]  best_mag;
   logic [IW-1:0]     best_idx;

`ifdef PEAK_HOLD_EN
   localparam int unsigned HW = (HOLD_FRAMES <= 1) ? 1 : $clog2(HOLD_FRAMES);
   logic [MAG_W-1:0]  held_mag;
   logic [HW-1:0]     hold_cnt;
`endif

   assign accept   = (state == IDLE) && (frame_ready || pending);
   assign busy     = (state != IDLE);
   assign rd_addr  = counter;
   assign whichRAM = bank;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      rd_en      = 1'b0;
      case (state)
         IDLE:    if (accept) state_next = READ;
         READ: begin
            rd_en = 1'b1;
            if (counter == IW'(SAMPLES - 1)) state_next = DRAIN;
         end
         DRAIN:   state_next = PUBLISH;
         PUBLISH: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bank         <= '0;
         pending      <= 1'b0;
         counter      <= '0;
         rd_valid     <= 1'b0;
         rd_idx       <= '0;
         index_holder <= '0;
         done         <= 1'b0;
         frame_drop   <= 1'b0;
`ifdef PEAK_HOLD_EN
         held_mag     <= '0;
         hold_cnt     <= '0;
`endif
      end else begin
         frame_drop <= 1'b0;
         // Read data lags the strobe by one cycle, so tag it with the address it belongs to.
         rd_valid   <= rd_en;
         rd_idx     <= counter;

         if (state == READ) counter <= counter + 1'b1;

         if (accept) begin
            bank    <= ~bank;
            pending <= 1'b0;
            counter <= '0;
         end else if (frame_ready && busy) begin
            if (pending) frame_drop <= 1'b1;
            else         pending    <= 1'b1;
         end

         if (state == PUBLISH) begin
`ifdef PEAK_HOLD_EN
            if ((best_mag >= held_mag) || (hold_cnt == HW'(HOLD_FRAMES - 1))) begin
               index_holder <= best_idx;
               held_mag     <= best_mag;
               hold_cnt     <= '0;
               done         <= (best_mag >= thresh);
            end else begin
               hold_cnt     <= hold_cnt + 1'b1;
               done         <= (held_mag >= thresh);
            end
`else
            index_holder <= best_idx;
            done         <= (best_mag >= thresh);
`endif
         end
      end
   end

   argmax_tracker #(
      .MAG_W (MAG_W),
      .IDX_W (IW)
   ) u_argmax (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (accept),
      .valid    (rd_valid),
      .data     (rd_data),
      .idx      (rd_idx),
      .best_mag (best_mag),
      .best_idx (best_idx)
   );

endmodule

// File: tb/tb_peak_scan_ctrl.sv
// Directed bench for peak_scan_ctrl with a two-bank magnitude RAM model; covers PEAK_HOLD_EN too.
module tb_peak_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_ready = 1'b0;
   logic [15:0] thresh = '0;
   logic        rd_en;
   logic [4:0]  rd_addr;
   logic [15:0] rd_data = '0;
   logic [4:0]  index_holder;
   logic        whichRAM;
   logic        done;
   logic        busy;
   logic        frame_drop;

   logic [15:0] mem [2][32];

   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned rd_cnt [2];
   int unsigned rd_any = 0;
   int unsigned busy_cnt = 0;
   int unsigned drop_cnt = 0;

   peak_scan_ctrl #(
      .SAMPLES     (32),
      .MAG_W       (16),
      .HOLD_FRAMES (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_ready  (frame_ready),
      .thresh       (thresh),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .index_holder (index_holder),
      .whichRAM     (whichRAM),
      .done         (done),
      .busy         (busy),
      .frame_drop   (frame_drop)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[whichRAM][rd_addr];
   end

   always @(posedge clk) begin
      if (rd_en) begin
         rd_cnt[whichRAM] = rd_cnt[whichRAM] + 1;
         rd_any = rd_any + 1;
      end
      if (busy)       busy_cnt = busy_cnt + 1;
      if (frame_drop) drop_cnt = drop_cnt + 1;
   end

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      rd_cnt[0] = 0;
      rd_cnt[1] = 0;
      rd_any    = 0;
      busy_cnt  = 0;
      drop_cnt  = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      clear_stats();
   endtask

   task automatic fill_bank(input int b, input logic [15:0] v);
      for (int i = 0; i < 32; i++) mem[b][i] = v;
   endtask

   // Pulse frame_ready, then stop just after the publish edge (accept edge + 34).
   task automatic scan_frame();
      frame_ready = 1'b1;
      tick(1);
      frame_ready = 1'b0;
      clear_stats();
      tick(34);
   endtask

   initial begin
      rd_cnt[0] = 0;
      rd_cnt[1] = 0;
      fill_bank(0, 16'd0);
      fill_bank(1, 16'd0);

      // Reset then idle
      do_reset();
      tick(5);
      check("idle_index", index_holder, 0);
      check("idle_done", done, 0);
      check("idle_bank", whichRAM, 0);
      check("idle_busy", busy, 0);
      check("idle_rd_en", rd_any, 0);

      // Single peak with precise publish timing
      fill_bank(1, 16'd10);
      mem[1][21] = 16'd500;
      thresh = 16'd100;
      frame_ready = 1'b1;
      tick(1);
      frame_ready = 1'b0;
      clear_stats();
      check("peak_bank_at_accept", whichRAM, 1);
      tick(33);
      check("peak_index_before_publish", index_holder, 0);
      check("peak_busy_in_publish", busy, 1);
      tick(1);
      check("peak_index", index_holder, 21);
      check("peak_done", done, 1);
      check("peak_bank", whichRAM, 1);
      check("peak_reads_bank1", rd_cnt[1], 32);
      check("peak_reads_bank0", rd_cnt[0], 0);
      check("peak_busy_cycles", busy_cnt, 34);
      check("peak_busy_after", busy, 0);

      // Tie keeps the lower index
      do_reset();
      fill_bank(1, 16'd10);
      mem[1][5] = 16'd300;
      mem[1][9] = 16'd300;
      scan_frame();
      check("tie_index", index_holder, 5);
      check("tie_done", done, 1);

      // Silence below threshold
      do_reset();
      fill_bank(1, 16'd20);
      scan_frame();
      check("silent_index", index_holder, 0);
      check("silent_done", done, 0);

      // Flat frame exactly at threshold counts as valid
      do_reset();
      fill_bank(1, 16'd100);
      scan_frame();
      check("at_thresh_index", index_holder, 0);
      check("at_thresh_done", done, 1);

      // All-zero frame with zero threshold
      do_reset();
      fill_bank(1, 16'd0);
      thresh = 16'd0;
      scan_frame();
      check("zero_index", index_holder, 0);
      check("zero_done", done, 1);
      thresh = 16'd100;

      // Back-to-back frames with one pending and one dropped
      do_reset();
      fill_bank(1, 16'd10);
      mem[1][21] = 16'd500;
      fill_bank(0, 16'd10);
      mem[0][3] = 16'd700;
      frame_ready = 1'b1;
      tick(1);
      frame_ready = 1'b0;
      clear_stats();
      tick(3);
      frame_ready = 1'b1;
      tick(1);
      frame_ready = 1'b0;
      check("b2b_no_drop_on_pending", frame_drop, 0);
      tick(6);
      frame_ready = 1'b1;
      tick(1);
      frame_ready = 1'b0;
      check("b2b_drop_pulse", frame_drop, 1);
      tick(1);
      check("b2b_drop_cleared", frame_drop, 0);
      check("b2b_bank_mid_scan", whichRAM, 1);
      tick(22);
      check("b2b_first_index", index_holder, 21);
      check("b2b_first_bank", whichRAM, 1);
      tick(1);
      check("b2b_second_bank", whichRAM, 0);
      check("b2b_second_busy", busy, 1);
      tick(34);
      check("b2b_second_index", index_holder, 3);
      check("b2b_second_done", done, 1);
      check("b2b_reads_bank0", rd_cnt[0], 32);
      check("b2b_reads_bank1", rd_cnt[1], 32);
      check("b2b_drop_count", drop_cnt, 1);
      check("b2b_idle_after", busy, 0);

      // Reset in the middle of a scan
      do_reset();
      fill_bank(1, 16'd10);
      mem[1][21] = 16'd500;
      frame_ready = 1'b1;
      tick(1);
      frame_ready = 1'b0;
      tick(12);
      rst_n = 1'b0;
      tick(1);
      check("rst_mid_index", index_holder, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_bank", whichRAM, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_rd_en", rd_en, 0);
      rst_n = 1'b1;
      tick(1);
      scan_frame();
      check("rst_next_reads_bank1", rd_cnt[1], 32);
      check("rst_next_index", index_holder, 21);
      check("rst_next_done", done, 1);

      // Peak hold sequence; without the hold every frame publishes directly
      do_reset();
      fill_bank(1, 16'd10);
      mem[1][7] = 16'd800;
      fill_bank(0, 16'd10);
      mem[0][3] = 16'd200;
      scan_frame();
      check("hold_f1_index", index_holder, 7);
      fill_bank(1, 16'd10);
      mem[1][3] = 16'd200;
      for (int f = 2; f <= 5; f++) begin
         scan_frame();
`ifdef PEAK_HOLD_EN
         check($sformatf("hold_f%0d_index", f), index_holder, (f == 5) ? 3 : 7);
`else
         check($sformatf("hold_f%0d_index", f), index_holder, 3);
`endif
         check($sformatf("hold_f%0d_done", f), done, 1);
      end
      fill_bank(0, 16'd10);
      mem[0][2] = 16'd900;
      scan_frame();
      check("hold_f6_bank", whichRAM, 0);
      check("hold_f6_index", index_holder, 2);
      check("hold_f6_done", done, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
